// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with retired-instruction counter
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                Zero,
    output logic [1:0]          NPCOp,
    output logic [2:0]          ALUOp,
    output logic [1:0]          A3WRSel,
    output logic [1:0]          WDSel,
    output logic                EXTOp,
    output logic                RFWE,
    output logic                ALUBSel,
    output logic                DMWr,
    output logic                PCWr,
    output logic                IRWr,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_ILL
    } instr_t;

    state_t                state_q, state_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    instr_t                instr;
    logic [2:0]            alu_op_dec;
    logic                  alu_bsel_dec;
    logic                  ext_dec;
    logic                  alu_drive;

    always_comb begin
        instr        = I_ILL;
        alu_op_dec   = 3'b000;
        alu_bsel_dec = 1'b0;
        ext_dec      = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: begin instr = I_SUBU; alu_op_dec = 3'b001; end
                    6'b001000: instr = I_JR;
                    6'b000000: instr = I_NOP;
                    default:   instr = I_ILL;
                endcase
            end
            6'b001101: begin instr = I_ORI; alu_op_dec = 3'b010; alu_bsel_dec = 1'b1; end
            6'b100011: begin instr = I_LW;  alu_bsel_dec = 1'b1; ext_dec = 1'b1; end
            6'b101011: begin instr = I_SW;  alu_bsel_dec = 1'b1; ext_dec = 1'b1; end
            6'b000100: begin instr = I_BEQ; alu_op_dec = 3'b001; ext_dec = 1'b1; end
            6'b001111: begin instr = I_LUI; alu_op_dec = 3'b011; alu_bsel_dec = 1'b1; end
            6'b000011: instr = I_JAL;
            default:   instr = I_ILL;
        endcase
    end

    always_comb begin
        state_d   = S_FETCH;
        NPCOp     = 2'b00;
        ALUOp     = 3'b000;
        A3WRSel   = 2'b00;
        WDSel     = 2'b00;
        EXTOp     = 1'b0;
        RFWE      = 1'b0;
        ALUBSel   = 1'b0;
        DMWr      = 1'b0;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        illegal   = 1'b0;
        alu_drive = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWr    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instr == I_NOP || instr == I_ILL) begin
                    PCWr    = 1'b1;
                    illegal = (instr == I_ILL);
                    state_d = S_FETCH;
                end else if (instr == I_JAL) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_drive = 1'b1;
                if (instr == I_BEQ) begin
                    PCWr    = 1'b1;
                    NPCOp   = Zero ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (instr == I_JR) begin
                    PCWr    = 1'b1;
                    NPCOp   = 2'b11;
                    state_d = S_FETCH;
                end else if (instr == I_LW || instr == I_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_drive = 1'b1;
                if (instr == I_SW) begin
                    DMWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                alu_drive = 1'b1;
                RFWE      = 1'b1;
                PCWr      = 1'b1;
                state_d   = S_FETCH;
                case (instr)
                    I_ADDU, I_SUBU: A3WRSel = 2'b01;
                    I_LW:           WDSel   = 2'b01;
                    I_JAL: begin
                        A3WRSel = 2'b10;
                        WDSel   = 2'b10;
                        NPCOp   = 2'b10;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        if (alu_drive) begin
            ALUOp   = alu_op_dec;
            ALUBSel = alu_bsel_dec;
            EXTOp   = ext_dec;
        end

        // Reset overrides the FETCH-state IRWr and any in-flight commit strobes.
        if (!reset) begin
            NPCOp   = 2'b00;
            ALUOp   = 3'b000;
            A3WRSel = 2'b00;
            WDSel   = 2'b00;
            EXTOp   = 1'b0;
            RFWE    = 1'b0;
            ALUBSel = 1'b0;
            DMWr    = 1'b0;
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            illegal = 1'b0;
        end

        retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, (PCWr & ~illegal)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int RW = 4;
    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_LUI = 8, K_JAL = 9, K_ILL = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = 6'd0, funct = 6'd0;
    logic          Zero = 1'b0;
    logic [1:0]    NPCOp, A3WRSel, WDSel;
    logic [2:0]    ALUOp, state;
    logic          EXTOp, RFWE, ALUBSel, DMWr, PCWr, IRWr, illegal;
    logic [RW-1:0] retired;

    int tests = 0, fails = 0;
    int ret_exp = 0;
    logic [5:0] op_tab [10];
    logic [5:0] fn_tab [10];

    multicycle_ctrl #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .NPCOp(NPCOp), .ALUOp(ALUOp), .A3WRSel(A3WRSel), .WDSel(WDSel), .EXTOp(EXTOp),
        .RFWE(RFWE), .ALUBSel(ALUBSel), .DMWr(DMWr), .PCWr(PCWr), .IRWr(IRWr),
        .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: case (fn)
                6'b100001: return K_ADDU;
                6'b100011: return K_SUBU;
                6'b001000: return K_JR;
                6'b000000: return K_NOP;
                default:   return K_ILL;
            endcase
            6'b001101: return K_ORI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001111: return K_LUI;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int path_len(input int kd);
        if (kd == K_NOP || kd == K_ILL) return 2;
        if (kd == K_JAL || kd == K_BEQ || kd == K_JR) return 3;
        if (kd == K_LW) return 5;
        return 4;
    endfunction

    // Visited states listed by position within the instruction
    function automatic logic [2:0] path_state(input int kd, input int k);
        if (k <= 1) return k[2:0];
        if (kd == K_JAL) return 3'b100;
        if (k == 2) return 3'b010;
        if (k == 3) return (kd == K_LW || kd == K_SW) ? 3'b011 : 3'b100;
        return 3'b100;
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int max_k);
        int kd, len, last;
        bit wr, alu_care, ext_care, phase2;
        logic [1:0] e_npc, e_a3, e_wd;
        logic [2:0] e_alu;
        logic e_bsel, e_ext;
        kd   = classify(op, fn);
        len  = path_len(kd);
        last = len - 1;
        wr   = (kd == K_ADDU || kd == K_SUBU || kd == K_ORI || kd == K_LUI || kd == K_LW || kd == K_JAL);
        for (int k = 0; k < len && k < max_k; k++) begin
            @(negedge clk);
            if (k == 0) begin opcode = op; funct = fn; end
            Zero = 1'($urandom);
            #1;
            if (k == 0) begin
                tests++;
                if (retired !== RW'(ret_exp)) begin
                    fails++;
                    $display("FAIL retired op=%b: got %0d want %0d", op, retired, ret_exp);
                end
            end
            tests++;
            if (state !== path_state(kd, k)) begin
                fails++;
                $display("FAIL state op=%b fn=%b k=%0d: got %b want %b", op, fn, k, state, path_state(kd, k));
            end
            tests++;
            if ({IRWr, PCWr, illegal, RFWE, DMWr} !==
                {k == 0, k == last, kd == K_ILL && k == last, wr && k == last, kd == K_SW && k == last}) begin
                fails++;
                $display("FAIL strobes op=%b k=%0d: got IRWr/PCWr/ill/RFWE/DMWr=%b%b%b%b%b want %b%b%b%b%b",
                         op, k, IRWr, PCWr, illegal, RFWE, DMWr, k == 0, k == last,
                         kd == K_ILL && k == last, wr && k == last, kd == K_SW && k == last);
            end
            e_npc = 2'b00;
            if (k == last) begin
                if (kd == K_JAL) e_npc = 2'b10;
                else if (kd == K_JR) e_npc = 2'b11;
                else if (kd == K_BEQ) e_npc = Zero ? 2'b01 : 2'b00;
            end
            tests++;
            if (NPCOp !== e_npc) begin
                fails++;
                $display("FAIL npcop op=%b k=%0d zero=%b: got %b want %b", op, k, Zero, NPCOp, e_npc);
            end
            if (wr && k == last) begin
                e_a3 = (kd == K_ADDU || kd == K_SUBU) ? 2'b01 : (kd == K_JAL) ? 2'b10 : 2'b00;
                e_wd = (kd == K_LW) ? 2'b01 : (kd == K_JAL) ? 2'b10 : 2'b00;
                tests++;
                if ({A3WRSel, WDSel} !== {e_a3, e_wd}) begin
                    fails++;
                    $display("FAIL wbsel op=%b: got a3=%b wd=%b want a3=%b wd=%b", op, A3WRSel, WDSel, e_a3, e_wd);
                end
            end
            phase2   = (k >= 2);
            alu_care = !phase2 || kd == K_ADDU || kd == K_SUBU || kd == K_ORI || kd == K_LUI || kd == K_LW || kd == K_SW;
            ext_care = !phase2 || kd == K_ORI || kd == K_LW || kd == K_SW;
            e_alu  = !phase2 ? 3'b000 : (kd == K_SUBU) ? 3'b001 : (kd == K_ORI) ? 3'b010 : (kd == K_LUI) ? 3'b011 : 3'b000;
            e_bsel = phase2 && (kd == K_ORI || kd == K_LUI || kd == K_LW || kd == K_SW);
            e_ext  = phase2 && (kd == K_LW || kd == K_SW);
            if (alu_care) begin
                tests++;
                if ({ALUOp, ALUBSel} !== {e_alu, e_bsel}) begin
                    fails++;
                    $display("FAIL alu op=%b k=%0d: got aluop=%b bsel=%b want %b %b", op, k, ALUOp, ALUBSel, e_alu, e_bsel);
                end
            end
            if (ext_care) begin
                tests++;
                if (EXTOp !== e_ext) begin
                    fails++;
                    $display("FAIL extop op=%b k=%0d: got %b want %b", op, k, EXTOp, e_ext);
                end
            end
        end
        if (max_k >= len && kd != K_ILL) ret_exp = (ret_exp + 1) % (1 << RW);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            Zero = 1'($urandom);
            #1;
            tests++;
            if ({state, retired, IRWr, PCWr, RFWE, DMWr, illegal} !== {3'b000, RW'(0), 5'b0}) begin
                fails++;
                $display("FAIL reset: got state=%b retired=%0d strobes=%b%b%b%b%b want 000 0 00000",
                         state, retired, IRWr, PCWr, RFWE, DMWr, illegal);
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        ret_exp = 0;
    endtask

    task automatic test_directed();
        run_instr(6'b000000, 6'b100001, 9);
        run_instr(6'b100011, 6'b010101, 9);
        run_instr(6'b101011, 6'b000000, 9);
        run_instr(6'b000100, 6'b000000, 9);
        run_instr(6'b000100, 6'b000000, 9);
        run_instr(6'b000011, 6'b000000, 9);
        run_instr(6'b000000, 6'b001000, 9);
        run_instr(6'b111111, 6'b000000, 9);
        run_instr(6'b000000, 6'b111111, 9);
        run_instr(6'b000000, 6'b000000, 9);
    endtask

    task automatic test_random(input int n);
        int kd;
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            kd = $urandom_range(0, 10);
            fn = 6'($urandom);
            if (kd == K_ILL) begin
                do begin
                    op = 6'($urandom);
                    if ($urandom_range(0, 1) == 0) op = 6'b000000;
                end while (classify(op, fn) != K_ILL);
            end else begin
                op = op_tab[kd];
                if (op == 6'b000000) fn = fn_tab[kd];
            end
            run_instr(op, fn, 9);
        end
    endtask

    task automatic test_reset_mid();
        run_instr(6'b100011, 6'b000000, 4);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({state, retired, PCWr, RFWE, DMWr, IRWr} !== {3'b000, RW'(0), 4'b0}) begin
            fails++;
            $display("FAIL reset_mid: got state=%b retired=%0d PCWr/RFWE/DMWr/IRWr=%b%b%b%b want 000 0 0000",
                     state, retired, PCWr, RFWE, DMWr, IRWr);
        end
        ret_exp = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        run_instr(6'b000000, 6'b100001, 9);
        run_instr(6'b001111, 6'b000000, 9);
        @(negedge clk);
        #1;
        tests++;
        if (retired !== RW'(2)) begin
            fails++;
            $display("FAIL reset_mid_retired: got %0d want 2", retired);
        end
    endtask

    initial begin
        op_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101,
                   6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000011};
        fn_tab = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                   6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        test_reset();
        test_directed();
        test_random(300);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
